dmd_serial_tx: RTL and testbench

- Transmit end of the DMD serial link: serialises pixel bytes and settings bytes onto dotClock/dotData/dotReg/dotLatch.
- The LCD DMD driver's receiver accepts this stream.
- Sits in the video-processor FPGA, fed by frame-composition logic through a valid/ready byte interface.
- Issues the end-of-frame latch that makes the receiver swap its double buffer and reload its settings pointer.

---
 rtl/dmd_serial_tx_if.sv | 25 ++
 rtl/dmd_serial_tx.sv | 190 +++++++++++++++++++
 tb/tb_dmd_serial_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmd_serial_tx_if.sv
// Byte handshake between frame-composition logic (master) and the DMD serial
// transmitter (slave). A byte is transferred on a cycle with tx_valid && tx_ready.
interface dmd_serial_tx_if;
  logic [7:0] tx_data;
  logic       tx_reg;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_reg,
    output tx_last,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_reg,
    input  tx_last,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/dmd_serial_tx.sv
// Transmit end of the DMD serial link. Serialises pixel/settings bytes MSB
// first onto dot_clock/dot_data/dot_reg and issues the end-of-frame latch
// that swaps the receiver's double buffer.
// Build option: define DMD_TX_AUTOLATCH_EN to latch automatically once
// FRAME_BYTES pixel bytes have been sent since the previous latch.
module dmd_serial_tx #(
  parameter int unsigned CLK_HALF    = 8,
  parameter int unsigned LATCH_GAP   = 16,
  parameter int unsigned FRAME_BYTES = 8192
) (
  input  logic                  clock_50,
  input  logic                  reset,
  dmd_serial_tx_if.slave        tx,
  input  logic                  latch_req,
  output logic                  dot_clock,
  output logic                  dot_data,
  output logic [2:0]            dot_reg,
  output logic                  dot_latch,
  output logic                  dot_enable,
  output logic [13:0]           pixel_count,
  output logic                  busy
);

`ifdef DMD_TX_AUTOLATCH_EN
  localparam bit AutoLatch = 1'b1;
`else
  localparam bit AutoLatch = 1'b0;
`endif

  localparam logic [15:0] HalfLast  = 16'(CLK_HALF - 1);
  localparam logic [15:0] GapLast   = 16'(LATCH_GAP - 1);
  localparam logic [14:0] FrameSize = 15'(FRAME_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StBitLo,
    StBitHi,
    StLatchSetup,
    StLatchHi,
    StLatchLo,
    StGap
  } state_e;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic        last_q;

  logic        half_done;
  logic        gap_done;
  logic [14:0] pix_next;
  logic        frame_full;

  // Phase/gap timers and the frame-boundary test for the byte just finishing.
  always_comb begin
    half_done  = (cnt_q == HalfLast);
    gap_done   = (cnt_q == GapLast);
    pix_next   = {1'b0, pixel_count} + 15'd1;
    frame_full = AutoLatch && (pix_next == FrameSize);
  end

  // Transmit FSM; every output is registered and changes on state transitions.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      // Leaving reset runs a full latch sequence to realign the receiver.
      state_q     <= StLatchSetup;
      cnt_q       <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      last_q      <= 1'b0;
      dot_clock   <= 1'b0;
      dot_data    <= 1'b0;
      dot_reg     <= '0;
      dot_latch   <= 1'b0;
      dot_enable  <= 1'b0;
      tx.tx_ready <= 1'b0;
      pixel_count <= '0;
      busy        <= 1'b1;
    end else begin
      dot_enable <= 1'b1;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (tx.tx_valid && tx.tx_ready) begin
            // A byte wins over a same-cycle latch_req.
            shift_q     <= tx.tx_data;
            last_q      <= tx.tx_last;
            bit_idx_q   <= 3'd7;
            dot_data    <= tx.tx_data[7];
            dot_reg     <= {2'b00, tx.tx_reg};
            dot_clock   <= 1'b0;
            tx.tx_ready <= 1'b0;
            busy        <= 1'b1;
            state_q     <= StBitLo;
          end else if (latch_req) begin
            dot_latch   <= 1'b1;
            dot_data    <= 1'b0;
            dot_reg     <= '0;
            tx.tx_ready <= 1'b0;
            busy        <= 1'b1;
            state_q     <= StLatchSetup;
          end
        end
        StBitLo: begin
          if (half_done) begin
            cnt_q     <= '0;
            dot_clock <= 1'b1;
            state_q   <= StBitHi;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StBitHi: begin
          if (half_done) begin
            cnt_q     <= '0;
            dot_clock <= 1'b0;
            if (bit_idx_q != 3'd0) begin
              shift_q   <= {shift_q[6:0], 1'b0};
              dot_data  <= shift_q[6];
              bit_idx_q <= bit_idx_q - 3'd1;
              state_q   <= StBitLo;
            end else begin
              if (!dot_reg[0]) begin
                pixel_count <= pix_next[13:0];
              end
              if (last_q || (!dot_reg[0] && frame_full)) begin
                dot_latch <= 1'b1;
                dot_data  <= 1'b0;
                dot_reg   <= '0;
                state_q   <= StLatchSetup;
              end else begin
                tx.tx_ready <= 1'b1;
                busy        <= 1'b0;
                state_q     <= StIdle;
              end
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StLatchSetup: begin
          // Also raises dot_latch when this state is entered straight from reset.
          dot_latch <= 1'b1;
          if (half_done) begin
            cnt_q     <= '0;
            dot_clock <= 1'b1;
            state_q   <= StLatchHi;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StLatchHi: begin
          if (half_done) begin
            cnt_q     <= '0;
            dot_clock <= 1'b0;
            state_q   <= StLatchLo;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StLatchLo: begin
          if (half_done) begin
            cnt_q       <= '0;
            dot_latch   <= 1'b0;
            pixel_count <= '0;
            state_q     <= StGap;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StGap: begin
          if (gap_done) begin
            cnt_q       <= '0;
            tx.tx_ready <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmd_serial_tx.sv
// Self-checking bench for dmd_serial_tx: directed and random bytes checked
// against a byte-level model of the expected dot_clock edges, handshake
// latency and pixel count.
module tb_dmd_serial_tx;
  localparam int unsigned CH  = 2;
  localparam int unsigned GAP = 4;
  localparam int unsigned FB  = 4;

`ifdef DMD_TX_AUTOLATCH_EN
  localparam bit AutoLatch = 1'b1;
`else
  localparam bit AutoLatch = 1'b0;
`endif

  logic        clock_50 = 1'b0;
  logic        reset = 1'b1;
  logic        latch_req = 1'b0;
  logic        dot_clock;
  logic        dot_data;
  logic [2:0]  dot_reg;
  logic        dot_latch;
  logic        dot_enable;
  logic [13:0] pixel_count;
  logic        busy;

  dmd_serial_tx_if txif ();

  dmd_serial_tx #(
    .CLK_HALF    (CH),
    .LATCH_GAP   (GAP),
    .FRAME_BYTES (FB)
  ) dut (
    .clock_50    (clock_50),
    .reset       (reset),
    .tx          (txif),
    .latch_req   (latch_req),
    .dot_clock   (dot_clock),
    .dot_data    (dot_data),
    .dot_reg     (dot_reg),
    .dot_latch   (dot_latch),
    .dot_enable  (dot_enable),
    .pixel_count (pixel_count),
    .busy        (busy)
  );

  always #5 clock_50 = ~clock_50;

  int vectors = 0;
  int miscompares = 0;
  int pc = 0;                 // model pixel count
  logic [4:0] edge_q[$];      // observed rising edges {latch, data, reg}
  logic [4:0] exp_q[$];       // expected rising edges

  logic       pclk = 1'b0;
  logic       pdata = 1'b0;
  logic       platch = 1'b0;
  logic [2:0] preg = 3'b000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Capture every dot_clock rising edge; data, reg and latch must hold while high.
  always @(negedge clock_50) begin
    if (dot_clock === 1'b1 && pclk === 1'b0) edge_q.push_back({dot_latch, dot_data, dot_reg});
    if (dot_clock === 1'b1 && pclk === 1'b1) begin
      chk("hi_data_stable", 32'(dot_data), 32'(pdata));
      chk("hi_reg_stable", 32'(dot_reg), 32'(preg));
      chk("hi_latch_stable", 32'(dot_latch), 32'(platch));
    end
    pclk   <= dot_clock;
    pdata  <= dot_data;
    preg   <= dot_reg;
    platch <= dot_latch;
  end

  // Cycles from the current edge until tx_ready is seen high (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clock_50);
      #1;
      n++;
      if (n == 3) txif.tx_valid = 1'b0;
    end while (txif.tx_ready !== 1'b1 && n < 400);
  endtask

  task automatic check_edges();
    logic [4:0] e;
    logic [4:0] x;
    chk("edge_count", 32'(edge_q.size()), 32'(exp_q.size()));
    while (edge_q.size() > 0 && exp_q.size() > 0) begin
      e = edge_q.pop_front();
      x = exp_q.pop_front();
      chk("edge_latch", 32'(e[4]), 32'(x[4]));
      if (!x[4]) chk("edge_data_reg", 32'(e[3:0]), 32'(x[3:0]));
    end
    edge_q.delete();
    exp_q.delete();
  endtask

  // Offer one byte (caller guarantees tx_ready), junk the inputs while busy,
  // then check latency, edges and pixel count against the model.
  task automatic send(input logic [7:0] d, input logic r, input logic l, input logic req);
    bit lat;
    int n;
    int exp_lat;
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, d[i], 2'b00, r});
    if (!r) pc = (pc + 1) % 16384;
    lat = l || (AutoLatch && !r && pc == FB);
    if (lat) begin
      exp_q.push_back(5'b10000);
      pc = 0;
    end
    exp_lat = 16 * CH + (lat ? 3 * CH + GAP : 0);
    txif.tx_data  = d;
    txif.tx_reg   = r;
    txif.tx_last  = l;
    txif.tx_valid = 1'b1;
    latch_req     = req;
    @(posedge clock_50);
    #1;
    latch_req     = 1'b0;
    txif.tx_data  = 8'($urandom);
    txif.tx_reg   = 1'($urandom);
    txif.tx_last  = 1'($urandom);
    chk("ready_drops", 32'(txif.tx_ready), 32'd0);
    wait_ready(n);
    chk("ready_latency", 32'(n), 32'(exp_lat));
    check_edges();
    chk("pixel_count", 32'(pixel_count), 32'(pc));
  endtask

  task automatic standalone_latch();
    int n;
    exp_q.push_back(5'b10000);
    pc = 0;
    latch_req = 1'b1;
    @(posedge clock_50);
    #1;
    latch_req = 1'b0;
    wait_ready(n);
    chk("latch_req_latency", 32'(n), 32'(3 * CH + GAP));
    check_edges();
    chk("latch_req_pixel_count", 32'(pixel_count), 32'(pc));
  endtask

  initial begin
    int n;
    logic [7:0] d;
    logic r;
    logic l;
    txif.tx_data  = 8'h00;
    txif.tx_reg   = 1'b0;
    txif.tx_last  = 1'b0;
    txif.tx_valid = 1'b0;

    // Reset values.
    repeat (3) @(posedge clock_50);
    #1;
    chk("rst_dot_clock", 32'(dot_clock), 32'd0);
    chk("rst_dot_data", 32'(dot_data), 32'd0);
    chk("rst_dot_reg", 32'(dot_reg), 32'd0);
    chk("rst_dot_latch", 32'(dot_latch), 32'd0);
    chk("rst_dot_enable", 32'(dot_enable), 32'd0);
    chk("rst_tx_ready", 32'(txif.tx_ready), 32'd0);
    chk("rst_pixel_count", 32'(pixel_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Resync latch after reset release.
    reset = 1'b0;
    exp_q.push_back(5'b10000);
    wait_ready(n);
    chk("resync_latency", 32'(n), 32'(3 * CH + GAP));
    check_edges();
    chk("resync_dot_enable", 32'(dot_enable), 32'd1);
    chk("resync_busy", 32'(busy), 32'd0);

    // Directed bytes.
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0, 1'b0);
    send(8'hB1, 1'b1, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b1, 1'b0);

    // Frame of FB pixel bytes without tx_last.
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 1'b0, 1'b0);
    standalone_latch();

    // Byte and latch_req in the same cycle: byte wins.
    send(8'h5A, 1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      r = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 5) == 0);
      send(d, r, l, 1'b0);
    end

    // Reset at the 4th bit of 0xFF.
    txif.tx_data  = 8'hFF;
    txif.tx_reg   = 1'b0;
    txif.tx_last  = 1'b0;
    txif.tx_valid = 1'b1;
    @(posedge clock_50);
    #1;
    txif.tx_valid = 1'b0;
    n = 0;
    while (edge_q.size() < 4 && n < 200) begin
      @(posedge clock_50);
      #1;
      n++;
    end
    chk("reset_point_reached", 32'(edge_q.size() >= 4), 32'd1);
    reset = 1'b1;
    @(posedge clock_50);
    #1;
    chk("midrst_dot_clock", 32'(dot_clock), 32'd0);
    chk("midrst_dot_data", 32'(dot_data), 32'd0);
    chk("midrst_dot_reg", 32'(dot_reg), 32'd0);
    chk("midrst_dot_enable", 32'(dot_enable), 32'd0);
    chk("midrst_tx_ready", 32'(txif.tx_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_pixel_count", 32'(pixel_count), 32'd0);
    edge_q.delete();
    exp_q.delete();
    pc = 0;
    @(posedge clock_50);
    #1;
    reset = 1'b0;
    exp_q.push_back(5'b10000);
    wait_ready(n);
    chk("midrst_resync_latency", 32'(n), 32'(3 * CH + GAP));
    check_edges();
    send(8'h96, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
